// File: rtl/wbuffer_queue.sv
// Speculative store write buffer.
// One circular buffer holds committed entries [head,cmt) and speculative
// entries [cmt,tail). Committed entries drain in order to memory, a flush
// drops the speculative part, and loads can forward bytes from any live entry.
module wbuffer_queue #(
    parameter int  DEPTH   = 8,
    parameter int  ADDR_W  = 32,
    parameter type msize_t = logic [1:0],
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wreq_valid,
    input  logic [ADDR_W-1:0] wreq_addr,
    input  msize_t            wreq_msize,
    input  logic [7:0]        wreq_strobe,
    input  logic [63:0]       wreq_data,
    output logic              wreq_ready,
    input  logic              creq_valid,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rreq_addr,
    output logic [7:0]        rresp_valid,
    output logic [63:0]       rresp_data,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output msize_t            mem_msize,
    output logic [7:0]        mem_strobe,
    output logic [63:0]       mem_data,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = CNT_W - 1;

    // Pointers carry an extra wrap bit above the index bits.
    logic [CNT_W-1:0] head_reg, cmt_reg, tail_reg;
    logic [CNT_W-1:0] head_next, cmt_next, tail_next;
    logic [IDX_W-1:0] head_idx, tail_idx;

    // Entry storage is read by every entry in parallel for forwarding,
    // so it is kept as a register array rather than a RAM.
    logic [ADDR_W-1:0] addr_mem   [DEPTH];
    msize_t            msize_mem  [DEPTH];
    logic [7:0]        strobe_mem [DEPTH];
    logic [63:0]       data_mem   [DEPTH];

    logic       do_push, do_commit, do_pop;
    logic [7:0] hit_byte [DEPTH];
    logic [IDX_W-1:0] fwd_idx;

    // Only the aligned word address participates in forwarding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^rreq_addr[2:0];

    assign head_idx = head_reg[IDX_W-1:0];
    assign tail_idx = tail_reg[IDX_W-1:0];

    assign count      = tail_reg - head_reg;
    assign empty      = (head_reg == tail_reg);
    assign full       = (head_idx == tail_idx) && (head_reg[CNT_W-1] != tail_reg[CNT_W-1]);
    assign wreq_ready = !full && !flush;
    assign mem_valid  = (head_reg != cmt_reg);

    assign do_push   = wreq_valid && wreq_ready;
    assign do_commit = creq_valid && (cmt_reg != tail_reg);
    assign do_pop    = mem_valid && mem_ready;

    assign mem_addr   = addr_mem[head_idx];
    assign mem_msize  = msize_mem[head_idx];
    assign mem_strobe = strobe_mem[head_idx];
    assign mem_data   = data_mem[head_idx];

    // Pointer updates; a flush rewinds tail to the commit point after any
    // same-cycle commit so that the just-committed entry survives.
    always_comb begin
        head_next = do_pop ? head_reg + CNT_W'(1) : head_reg;
        cmt_next  = do_commit ? cmt_reg + CNT_W'(1) : cmt_reg;
        tail_next = tail_reg;
        if (flush) begin
            tail_next = cmt_next;
        end else if (do_push) begin
            tail_next = tail_reg + CNT_W'(1);
        end
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg <= '0;
            cmt_reg  <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            cmt_reg  <= cmt_next;
            tail_reg <= tail_next;
        end
    end

    // Entry write at tail; contents need no reset since pointers qualify them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[tail_idx]   <= wreq_addr;
            msize_mem[tail_idx]  <= wreq_msize;
            strobe_mem[tail_idx] <= wreq_strobe;
            data_mem[tail_idx]   <= wreq_data;
        end
    end

    // Per-entry byte hits: entry must be live (age below count) and match
    // the load's aligned word address.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [IDX_W-1:0] age;
            logic             live;
            assign age  = IDX_W'(gi) - head_idx;
            assign live = ({1'b0, age} < count);
            assign hit_byte[gi] = (live && (addr_mem[gi][ADDR_W-1:3] == rreq_addr[ADDR_W-1:3]))
                                  ? strobe_mem[gi] : 8'h00;
        end
    endgenerate

    // Forward merge: walk oldest to youngest so the youngest hit wins per byte.
    always_comb begin
        rresp_valid = '0;
        rresp_data  = '0;
        fwd_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_idx + IDX_W'(i);
            for (int b = 0; b < 8; b++) begin
                if (hit_byte[fwd_idx][b]) begin
                    rresp_valid[b]       = 1'b1;
                    rresp_data[8*b +: 8] = data_mem[fwd_idx][8*b +: 8];
                end
            end
        end
    end

endmodule
